// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction RAM and
// registers the same-cycle read data into the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if_i,
  input  logic        stall_id_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic [31:0] inst_i,
  output logic        inst_ce_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_adel_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

  function automatic logic is_misaligned(input logic [31:0] addr);
    is_misaligned = (addr[1:0] != 2'b00);
  endfunction

  logic [31:0] pc_r;
  logic        ce_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_inst_r;
  logic        id_valid_r;
  logic        id_adel_r;
  logic [31:0] fetch_count_r;

  logic        misalign_s;
  logic        hold_s;
  logic        bubble_s;
  logic        capture_s;
  logic        fetch_ok_s;
  logic [31:0] pc_next_s;
  logic [31:0] id_pc_next_s;
  logic [31:0] id_inst_next_s;
  logic        id_valid_next_s;
  logic        id_adel_next_s;
  logic [31:0] fetch_count_next_s;

  assign misalign_s = is_misaligned(pc_r);
  assign hold_s     = stall_if_i | stall_id_i;
  // A stalled IF with a free ID hands decode a bubble rather than a duplicate.
  assign bubble_s   = flush_i | (stall_if_i & ~stall_id_i);
  assign capture_s  = ~flush_i & ~hold_s;
  assign fetch_ok_s = ce_r & ~misalign_s;

  // Next PC: startup hold, flush, stall, branch, then sequential step.
  always_comb begin
    pc_next_s = pc_r;
    if (!ce_r) begin
      pc_next_s = RESET_PC;
    end else if (flush_i) begin
      pc_next_s = new_pc_i;
    end else if (hold_s) begin
      pc_next_s = pc_r;
    end else if (branch_flag_i) begin
      pc_next_s = branch_target_i;
    end else begin
      pc_next_s = pc_r + PC_STEP_W;
    end
  end

  // Next IF/ID contents: bubble, hold, or capture of the current fetch.
  always_comb begin
    id_pc_next_s    = id_pc_r;
    id_inst_next_s  = id_inst_r;
    id_valid_next_s = id_valid_r;
    id_adel_next_s  = id_adel_r;
    if (bubble_s) begin
      id_pc_next_s    = 32'h0000_0000;
      id_inst_next_s  = 32'h0000_0000;
      id_valid_next_s = 1'b0;
      id_adel_next_s  = 1'b0;
    end else if (stall_id_i) begin
      id_pc_next_s    = id_pc_r;
      id_inst_next_s  = id_inst_r;
      id_valid_next_s = id_valid_r;
      id_adel_next_s  = id_adel_r;
    end else begin
      id_pc_next_s    = pc_r;
      id_inst_next_s  = fetch_ok_s ? inst_i : 32'h0000_0000;
      id_valid_next_s = ce_r;
      id_adel_next_s  = ce_r & misalign_s;
    end
  end

  // Fetch counter includes misaligned captures; they still occupy the ID slot.
  always_comb begin
    fetch_count_next_s = fetch_count_r;
    if (capture_s && ce_r) begin
      fetch_count_next_s = fetch_count_r + 32'd1;
    end else begin
      fetch_count_next_s = fetch_count_r;
    end
  end

  // PC and chip-enable state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
      ce_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      ce_r <= 1'b1;
    end
  end

  // IF/ID pipeline register and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_r       <= 32'h0000_0000;
      id_inst_r     <= 32'h0000_0000;
      id_valid_r    <= 1'b0;
      id_adel_r     <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      id_pc_r       <= id_pc_next_s;
      id_inst_r     <= id_inst_next_s;
      id_valid_r    <= id_valid_next_s;
      id_adel_r     <= id_adel_next_s;
      fetch_count_r <= fetch_count_next_s;
    end
  end

  assign inst_addr_o   = pc_r;
  assign inst_ce_o     = fetch_ok_s;
  assign id_pc_o       = id_pc_r;
  assign id_inst_o     = id_inst_r;
  assign id_valid_o    = id_valid_r;
  assign id_adel_o     = id_adel_r;
  assign fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a behavioural model pushes the expected
// IF/ID state per cycle, scenario tasks pop and compare after each edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if_i = 1'b0;
  logic        stall_id_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = 32'h0;
  logic [31:0] inst_i;
  logic        inst_ce_o;
  logic [31:0] inst_addr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_adel_o;
  logic [31:0] fetch_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [97:0] sb[$];
  logic [97:0] exp_v;
  logic [97:0] obs_s;
  assign obs_s = {id_pc_o, id_inst_o, id_valid_o, id_adel_o, fetch_count_o};

  // model state
  logic [31:0] m_pc = 32'h0;
  logic        m_ce = 1'b0;
  logic [31:0] m_id_pc = 32'h0, m_id_inst = 32'h0, m_cnt = 32'h0;
  logic        m_id_valid = 1'b0, m_id_adel = 1'b0;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h0) ram_word = 32'h3401_0001;
    else ram_word = {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  assign inst_i = ram_word(inst_addr_o);

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i), .inst_i(inst_i),
    .inst_ce_o(inst_ce_o), .inst_addr_o(inst_addr_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_valid_o(id_valid_o), .id_adel_o(id_adel_o),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  // Apply inputs for one cycle, predict the post-edge state, push it, clock.
  task automatic drive_cycle(input logic r, input logic sif, input logic sid,
                             input logic br, input logic [31:0] bt,
                             input logic fl, input logic [31:0] np);
    logic capture;
    logic aligned;
    rst = r; stall_if_i = sif; stall_id_i = sid; branch_flag_i = br;
    branch_target_i = bt; flush_i = fl; new_pc_i = np;
    #1;
    capture = !fl && !sif && !sid;
    aligned = (m_pc[1:0] == 2'b00);
    if (r) begin
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0; m_cnt = 0;
    end else if (fl || (sif && !sid)) begin
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_id_adel = 0;
    end else if (capture) begin
      m_id_pc = m_pc;
      m_id_inst = (m_ce && aligned) ? ram_word(m_pc) : 32'h0;
      m_id_valid = m_ce;
      m_id_adel = m_ce && !aligned;
      if (m_ce) m_cnt = m_cnt + 32'd1;
    end
    if (r) begin
      m_pc = 32'h0; m_ce = 1'b0;
    end else begin
      if (!m_ce) m_pc = 32'h0;
      else if (fl) m_pc = np;
      else if (sif || sid) m_pc = m_pc;
      else if (br) m_pc = bt;
      else m_pc = m_pc + 32'd4;
      m_ce = 1'b1;
    end
    sb.push_back({m_id_pc, m_id_inst, m_id_valid, m_id_adel, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic flush_to(input logic [31:0] target);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, target);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_s !== exp_v) $display("FAIL reset_id cyc%0d got %h want %h", i, obs_s, exp_v);
      else n_pass++;
    end
    n_checks++;
    if ({inst_ce_o, inst_addr_o} !== {1'b0, 32'h0})
      $display("FAIL reset_ce0 got ce=%b addr=%h want ce=0 addr=0", inst_ce_o, inst_addr_o);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v) $display("FAIL startup_id got %h want %h", obs_s, exp_v);
    else n_pass++;
    n_checks++;
    if ({inst_ce_o, inst_addr_o} !== {1'b1, 32'h0})
      $display("FAIL startup_ce1 got ce=%b addr=%h want ce=1 addr=0", inst_ce_o, inst_addr_o);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v) $display("FAIL first_fetch got %h want %h", obs_s, exp_v);
    else n_pass++;
    n_checks++;
    if ({id_pc_o, id_inst_o, id_valid_o, inst_addr_o} !== {32'h0, 32'h3401_0001, 1'b1, 32'h4})
      $display("FAIL first_fetch_const got pc=%h inst=%h v=%b addr=%h want 0/34010001/1/4",
               id_pc_o, id_inst_o, id_valid_o, inst_addr_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] c0;
    flush_to(32'hFFFF_FFFC);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v) $display("FAIL wrap_flush got %h want %h", obs_s, exp_v);
    else n_pass++;
    c0 = fetch_count_o;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || inst_addr_o !== 32'h0 || fetch_count_o !== c0 + 32'd1)
      $display("FAIL wrap_addr got id=%h addr=%h want id=%h addr=0", obs_s, inst_addr_o, exp_v);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || fetch_count_o !== c0 + 32'd2)
      $display("FAIL wrap_count got %h want %h", obs_s, exp_v);
    else n_pass++;
  endtask

  task automatic test_branch();
    logic [31:0] addrs[3];
    flush_to(32'h10);
    void'(sb.pop_front());
    addrs[0] = inst_addr_o;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || id_pc_o !== 32'h10)
      $display("FAIL branch_delay_slot got %h want %h", obs_s, exp_v);
    else n_pass++;
    addrs[1] = inst_addr_o;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || id_pc_o !== 32'h40)
      $display("FAIL branch_target got %h want %h", obs_s, exp_v);
    else n_pass++;
    addrs[2] = inst_addr_o;
    n_checks++;
    if ({addrs[0], addrs[1], addrs[2]} !== {32'h10, 32'h40, 32'h44})
      $display("FAIL branch_addrs got %h %h %h want 10 40 44", addrs[0], addrs[1], addrs[2]);
    else n_pass++;
  endtask

  task automatic test_stall();
    flush_to(32'h20);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_s !== exp_v || inst_addr_o !== 32'h20 || id_valid_o !== 1'b0)
        $display("FAIL stall_if cyc%0d got id=%h addr=%h want id=%h addr=20", i, obs_s, inst_addr_o, exp_v);
      else n_pass++;
    end
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || inst_addr_o !== 32'h20)
      $display("FAIL stall_both got id=%h addr=%h want id=%h addr=20", obs_s, inst_addr_o, exp_v);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || id_pc_o !== 32'h20 || id_valid_o !== 1'b1 || inst_addr_o !== 32'h24)
      $display("FAIL stall_release got id=%h addr=%h want id=%h addr=24", obs_s, inst_addr_o, exp_v);
    else n_pass++;
    // ID-only stall holds a real instruction and the PC, branch ignored
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_s !== exp_v || id_pc_o !== 32'h20 || inst_addr_o !== 32'h24)
        $display("FAIL stall_id cyc%0d got id=%h addr=%h want id=%h addr=24", i, obs_s, inst_addr_o, exp_v);
      else n_pass++;
    end
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || id_pc_o !== 32'h24)
      $display("FAIL stall_id_release got %h want %h", obs_s, exp_v);
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h180);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || inst_addr_o !== 32'h180 || id_valid_o !== 1'b0 || id_inst_o !== 32'h0)
      $display("FAIL flush_prio got id=%h addr=%h want id=%h addr=180", obs_s, inst_addr_o, exp_v);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || id_pc_o !== 32'h180)
      $display("FAIL flush_resume got %h want %h", obs_s, exp_v);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || inst_addr_o !== 32'h102 || inst_ce_o !== 1'b0)
      $display("FAIL misalign_ce got id=%h addr=%h ce=%b want id=%h addr=102 ce=0",
               obs_s, inst_addr_o, inst_ce_o, exp_v);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || {id_pc_o, id_inst_o, id_valid_o, id_adel_o} !== {32'h102, 32'h0, 1'b1, 1'b1})
      $display("FAIL misalign_capture got %h want %h", obs_s, exp_v);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    flush_to(32'h88);
    void'(sb.pop_front());
    idle_cycle();
    void'(sb.pop_front());
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || obs_s !== 98'h0 || inst_addr_o !== 32'h0 || inst_ce_o !== 1'b0)
      $display("FAIL midrun_reset got id=%h addr=%h ce=%b want all zero", obs_s, inst_addr_o, inst_ce_o);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || inst_ce_o !== 1'b1 || inst_addr_o !== 32'h0 || id_valid_o !== 1'b0)
      $display("FAIL midrun_startup got id=%h ce=%b addr=%h want id=%h", obs_s, inst_ce_o, inst_addr_o, exp_v);
    else n_pass++;
    idle_cycle();
    exp_v = sb.pop_front(); n_checks++;
    if (obs_s !== exp_v || {id_inst_o, fetch_count_o} !== {32'h3401_0001, 32'd1})
      $display("FAIL midrun_first_fetch got %h want %h", obs_s, exp_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      exp_v = sb.pop_front(); n_checks++;
      if (obs_s !== exp_v) $display("FAIL b2b cyc%0d got %h want %h", i, obs_s, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_stall();
    test_flush_priority();
    test_misaligned();
    test_midrun_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction RAM.
- Owns the PC register and drives the RAM's ce/addr.
- Captures the RAM's combinational read data (same cycle) into the IF/ID pipeline register for decode.
- Handles stall, branch redirect (MIPS delay-slot semantics, no squash), exception flush and misaligned-PC detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value held through reset and fetched first.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if_i  in  1  hold PC.
- stall_id_i  in  1  hold IF/ID register.
- branch_flag_i  in  1  redirect request from ID.
- branch_target_i  in  32  redirect target.
- flush_i  in  1  exception flush.
- new_pc_i  in  32  exception/ERET target.
- inst_i  in  32  RAM data_o (combinational read of inst_addr_o).
- inst_ce_o  out  1  RAM chip enable.
- inst_addr_o  out  32  RAM address (= pc).
- id_pc_o  out  32  PC of instruction in ID.
- id_inst_o  out  32  instruction in ID.
- id_valid_o  out  1  ID slot holds a real fetch.
- id_adel_o  out  1  address-error-on-fetch flag for ID.
- fetch_count_o  out  32  count of valid fetches captured.

Behaviour:
- Registers: pc, ce_r, id_pc, id_inst, id_valid, id_adel, fetch_count.
- Reset (rst=1 at edge):
  - pc=RESET_PC, ce_r=0.
  - All id_* outputs = 0.
  - fetch_count=0.
- Startup:
  - First edge with rst=0: ce_r<=1, pc stays RESET_PC.
  - First RAM access happens in the following cycle.
  - Reset asserted mid-operation returns to this sequence; no in-flight state survives.
- Misaligned PC: misalign = (pc[1:0] != 0).
- Combinational outputs:
  - inst_addr_o = pc.
  - inst_ce_o = ce_r & ~misalign.
- Hold signal: hold = stall_if_i | stall_id_i. stall_id_i without stall_if_i is treated as a full hold.
- PC next-state priority, highest first:
  1. rst
  2. ce_r=0: hold RESET_PC
  3. flush_i: new_pc_i
  4. hold: keep pc
  5. branch_flag_i: branch_target_i
  6. otherwise: pc+PC_STEP, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000)
- Branch rules:
  - A branch arriving during hold is not latched; ID keeps branch_flag_i asserted until the stall clears.
  - The instruction being fetched in the branch cycle (delay slot) is captured normally.
- IF/ID next-state priority, highest first:
  1. rst: zeros.
  2. flush_i: bubble (id_pc=0, id_inst=0, id_valid=0, id_adel=0).
  3. stall_if_i=1 and stall_id_i=0: bubble.
  4. stall_id_i=1: hold all id_*.
  5. Otherwise capture:
     - id_pc = pc
     - id_inst = (ce_r & ~misalign) ? inst_i : 0
     - id_valid = ce_r
     - id_adel = ce_r & misalign
- Simultaneous events:
  - flush_i wins over stall and branch in both the PC and IF/ID paths.
  - branch + flush: flush target is used.
- fetch_count increments by 1 on each capture with ce_r=1 (misaligned captures included). It wraps 32'hFFFF_FFFF -> 0 and is cleared only by rst.
- Latency: instruction at PC p appears on id_* one edge after inst_addr_o=p, absent hold.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0; RAM word0=32'h3401_0001.
  - One cycle with inst_ce_o=0, addr=0.
  - Next cycle inst_ce_o=1, addr=0.
  - After the following edge: id_pc=0, id_inst=32'h3401_0001, id_valid=1; next addr=4.
- Sequential and wrap: force pc to 32'hFFFF_FFFC via flush_i with new_pc_i=32'hFFFF_FFFC.
  - Next addr = 0.
  - fetch_count increments by 1 per cycle.
- Branch with delay slot: at pc=32'h10 assert branch_flag_i with target 32'h40 for one cycle.
  - id_pc sequence: 32'h10, 32'h40 (32'h10 is the delay slot, captured).
  - Address sequence: 32'h10, 32'h40, 32'h44.
- Stall: stall_if_i=1, stall_id_i=0 for 2 cycles at pc=32'h20.
  - addr held at 32'h20; id_valid=0 for 2 cycles.
  - Then stall_if_i=stall_id_i=1: id_* held.
  - On release: resumes at 32'h20 with no duplicate or lost fetch.
- Flush during stall + branch: flush_i=1, new_pc_i=32'h180, stall_if_i=1, branch_flag_i=1 in the same cycle.
  - Next addr = 32'h180.
  - id_valid=0, id_inst=0.
- Misaligned target: branch to 32'h0000_0102.
  - inst_ce_o=0 while addr=32'h102.
  - Captured id_adel=1, id_inst=0, id_valid=1, id_pc=32'h102.
- Mid-run reset: rst=1 for one cycle at pc=32'h88.
  - pc=RESET_PC, all id_*=0, fetch_count=0.
  - Startup sequence repeats.
